// File: rtl/sram_port_arbiter_pkg.sv
// Shared definitions for the SRAM port arbiter: requester port IDs and default starvation bound.
package sram_port_arbiter_pkg;

  typedef enum logic {
    ARB_ID_INST = 1'b0,
    ARB_ID_DATA = 1'b1
  } arb_id_e;

  localparam int unsigned STARVE_MAX_DEFAULT = 8;

endpackage

// File: rtl/sram_port_arbiter_starve_counter.sv
// Saturating count of consecutive refused inst cycles; hit flags that the bound is reached.
module arb_starve_counter
  import sram_port_arbiter_pkg::*;
#(
  parameter int unsigned MAX = STARVE_MAX_DEFAULT
) (
  input  logic clk,
  input  logic resetn,
  input  logic inc,
  input  logic clr,
  output logic hit
);

  localparam int unsigned W = (MAX < 1) ? 1 : $clog2(MAX + 1);
  localparam logic [W-1:0] MAX_V = W'(MAX);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != MAX_V)) begin
      cnt <= cnt + W'(1);
    end
  end

  assign hit = (cnt == MAX_V);

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one single-port SRAM between inst fetch and data access; data has fixed priority.
// Build option SRAM_ARB_STARVE_GUARD_EN adds a bounded-starvation forced inst grant.
module sram_port_arbiter
  import sram_port_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEFAULT
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        sram_en,
  output logic [3:0]  sram_wen,
  output logic [31:0] sram_addr,
  output logic [31:0] sram_wdata,
  input  logic [31:0] sram_rdata
);

  logic    starve_hit;
  logic    grant_inst;
  logic    grant_data;
  logic    pend_vld;
  logic    pend_wr;
  arb_id_e pend_id;

`ifdef SRAM_ARB_STARVE_GUARD_EN
  arb_starve_counter #(
    .MAX (STARVE_MAX)
  ) u_starve (
    .clk    (clk),
    .resetn (resetn),
    .inc    (inst_req && !grant_inst),
    .clr    (!inst_req || grant_inst),
    .hit    (starve_hit)
  );
`else
  assign starve_hit = 1'b0;
`endif

  // Grants are gated by resetn so every output reads 0 while reset is held.
  always_comb begin
    grant_data = resetn && data_req && !(inst_req && starve_hit);
    grant_inst = resetn && inst_req && !grant_data;
  end

  always_comb begin
    sram_en    = 1'b0;
    sram_wen   = '0;
    sram_addr  = '0;
    sram_wdata = '0;
    if (grant_data) begin
      sram_en    = 1'b1;
      sram_wen   = data_wr ? data_wstrb : 4'b0000;
      sram_addr  = data_addr;
      sram_wdata = data_wdata;
    end else if (grant_inst) begin
      sram_en    = 1'b1;
      sram_addr  = inst_addr;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pend_vld <= 1'b0;
      pend_id  <= ARB_ID_INST;
      pend_wr  <= 1'b0;
    end else begin
      pend_vld <= grant_data || grant_inst;
      pend_id  <= grant_data ? ARB_ID_DATA : ARB_ID_INST;
      pend_wr  <= grant_data && data_wr;
    end
  end

  assign inst_addr_ok = grant_inst;
  assign data_addr_ok = grant_data;
  assign inst_data_ok = pend_vld && (pend_id == ARB_ID_INST);
  assign data_data_ok = pend_vld && (pend_id == ARB_ID_DATA);
  assign inst_rdata   = inst_data_ok ? sram_rdata : '0;
  assign data_rdata   = (data_data_ok && !pend_wr) ? sram_rdata : '0;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Self-checking bench for sram_port_arbiter: behavioural SRAM, grant model and response scoreboard.
module tb_sram_port_arbiter;

  localparam int unsigned SMAX  = 8;
  localparam int unsigned WORDS = 4096;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req, data_wr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr, data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        sram_en;
  logic [3:0]  sram_wen;
  logic [31:0] sram_addr, sram_wdata;
  logic [31:0] sram_rdata;

  sram_port_arbiter #(.STARVE_MAX(SMAX)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .inst_req     (inst_req),
    .inst_addr    (inst_addr),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata),
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_wstrb   (data_wstrb),
    .data_addr    (data_addr),
    .data_wdata   (data_wdata),
    .data_addr_ok (data_addr_ok),
    .data_data_ok (data_data_ok),
    .data_rdata   (data_rdata),
    .sram_en      (sram_en),
    .sram_wen     (sram_wen),
    .sram_addr    (sram_addr),
    .sram_wdata   (sram_wdata),
    .sram_rdata   (sram_rdata)
  );

  always #5 clk = ~clk;

  logic [31:0] mem     [WORDS];
  logic [31:0] ref_mem [WORDS];

  // SRAM returns the addressed word on every enabled cycle, writes included.
  always @(posedge clk) begin
    if (sram_en) begin
      sram_rdata <= mem[sram_addr[13:2]];
      for (int b = 0; b < 4; b++)
        if (sram_wen[b]) mem[sram_addr[13:2]][8*b +: 8] <= sram_wdata[8*b +: 8];
    end
  end

  typedef struct {
    int unsigned due;
    logic        is_data;
    logic [31:0] rdata;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned errors = 0;
  int unsigned checks = 0;
  int unsigned cyc    = 0;
  int unsigned m_cnt  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    logic hit, gd, gi;
    if (!resetn) begin
      check("rst_inst_addr_ok", {31'b0, inst_addr_ok}, 32'd0);
      check("rst_data_addr_ok", {31'b0, data_addr_ok}, 32'd0);
      check("rst_inst_data_ok", {31'b0, inst_data_ok}, 32'd0);
      check("rst_data_data_ok", {31'b0, data_data_ok}, 32'd0);
      check("rst_inst_rdata", inst_rdata, 32'd0);
      check("rst_data_rdata", data_rdata, 32'd0);
      check("rst_sram_en", {31'b0, sram_en}, 32'd0);
      check("rst_sram_wen", {28'b0, sram_wen}, 32'd0);
      check("rst_sram_addr", sram_addr, 32'd0);
      exp_q.delete();
      m_cnt = 0;
    end else begin
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        e = exp_q.pop_front();
        check("inst_data_ok", {31'b0, inst_data_ok}, {31'b0, !e.is_data});
        check("data_data_ok", {31'b0, data_data_ok}, {31'b0, e.is_data});
        check("inst_rdata", inst_rdata, e.is_data ? 32'd0 : e.rdata);
        check("data_rdata", data_rdata, e.is_data ? e.rdata : 32'd0);
      end else begin
        check("idle_inst_data_ok", {31'b0, inst_data_ok}, 32'd0);
        check("idle_data_data_ok", {31'b0, data_data_ok}, 32'd0);
        check("idle_inst_rdata", inst_rdata, 32'd0);
        check("idle_data_rdata", data_rdata, 32'd0);
      end
`ifdef SRAM_ARB_STARVE_GUARD_EN
      hit = (m_cnt == SMAX);
`else
      hit = 1'b0;
`endif
      gd = data_req && !(inst_req && hit);
      gi = inst_req && !gd;
      check("inst_addr_ok", {31'b0, inst_addr_ok}, {31'b0, gi});
      check("data_addr_ok", {31'b0, data_addr_ok}, {31'b0, gd});
      check("sram_en", {31'b0, sram_en}, {31'b0, gd || gi});
      check("sram_addr", sram_addr, gd ? data_addr : (gi ? inst_addr : 32'd0));
      check("sram_wen", {28'b0, sram_wen}, {28'b0, (gd && data_wr) ? data_wstrb : 4'b0000});
      if (gd) check("sram_wdata", sram_wdata, data_wdata);
      if (gd) begin
        e.due     = cyc + 1;
        e.is_data = 1'b1;
        e.rdata   = data_wr ? 32'd0 : ref_mem[data_addr[13:2]];
        exp_q.push_back(e);
        if (data_wr)
          for (int b = 0; b < 4; b++)
            if (data_wstrb[b]) ref_mem[data_addr[13:2]][8*b +: 8] = data_wdata[8*b +: 8];
      end else if (gi) begin
        e.due     = cyc + 1;
        e.is_data = 1'b0;
        e.rdata   = ref_mem[inst_addr[13:2]];
        exp_q.push_back(e);
      end
      if (!inst_req || gi) m_cnt = 0;
      else if (m_cnt < SMAX) m_cnt++;
    end
    cyc++;
  end

  task automatic drive(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                       input logic [3:0] ds, input logic [31:0] da, input logic [31:0] dwd);
    inst_req   = ir;
    inst_addr  = ia;
    data_req   = dr;
    data_wr    = dw;
    data_wstrb = ds;
    data_addr  = da;
    data_wdata = dwd;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) drive(1'b0, '0, 1'b0, 1'b0, '0, '0, '0);
  endtask

  initial begin
    for (int i = 0; i < WORDS; i++) begin
      mem[i]     = 32'hC0DE_0000 ^ (i * 32'h0001_0111);
      ref_mem[i] = 32'hC0DE_0000 ^ (i * 32'h0001_0111);
    end
    sram_rdata = '0;
    resetn     = 1'b0;
    idle(3);
    resetn = 1'b1;
    idle(2);

    drive(1'b1, 32'hBFC0_0000, 1'b0, 1'b0, 4'h0, '0, '0);
    idle(2);

    drive(1'b1, 32'hBFC0_0004, 1'b1, 1'b0, 4'h0, 32'h0000_1000, '0);
    drive(1'b1, 32'hBFC0_0004, 1'b0, 1'b0, 4'h0, '0, '0);
    idle(2);

    drive(1'b0, '0, 1'b1, 1'b1, 4'b0011, 32'h0000_0020, 32'hAABB_CCDD);
    drive(1'b0, '0, 1'b1, 1'b0, 4'h0, 32'h0000_0020, '0);
    idle(2);

    for (int unsigned i = 0; i < 100; i++)
      drive(1'b1, 32'hBFC0_0008, 1'b1, 1'b0, 4'h0, 32'h0000_1004, '0);
    idle(2);

    for (int unsigned i = 0; i < 60; i++)
      drive(1'($urandom_range(0, 1)), {18'b0, 12'($urandom_range(0, 63)), 2'b00},
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
            {18'b0, 12'($urandom_range(0, 63)), 2'b00}, $urandom);
    idle(2);

    // Reset lands in the second half of the grant cycle, before the capturing edge.
    inst_req  = 1'b1;
    inst_addr = 32'hBFC0_0010;
    data_req  = 1'b1;
    data_wr   = 1'b0;
    data_addr = 32'h0000_0040;
    @(negedge clk);
    #1;
    resetn = 1'b0;
    @(posedge clk);
    #1;
    drive(1'b1, 32'hBFC0_0010, 1'b1, 1'b0, 4'h0, 32'h0000_0040, '0);
    inst_req = 1'b0;
    data_req = 1'b0;
    resetn   = 1'b1;
    idle(2);
    drive(1'b0, '0, 1'b1, 1'b0, 4'h0, 32'h0000_0020, '0);
    idle(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
